// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the full-speed USB receive front end:
// status codes, PID bytes, bus states and the CRC16 step function.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'b000,
    RX_IN    = 3'b001,
    RX_OUT   = 3'b010,
    RX_ACK   = 3'b011,
    RX_NAK   = 3'b100,
    RX_DONE  = 3'b101,
    RX_DATA  = 3'b110,
    RX_ERROR = 3'b111
  } rx_code_e;

  typedef enum logic [1:0] {
    BUS_J,
    BUS_K,
    BUS_SE0
  } bus_state_e;

  typedef enum logic [1:0] {
    PK_TOKEN,
    PK_HANDSHAKE,
    PK_DATA
  } pkt_kind_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // One serial CRC16 step, bits taken in wire order (LSB of each byte first).
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_rx_bit_decoder.sv
// Line-level receive path: synchronizers, bit-clock recovery, NRZI decode,
// bit unstuffing and SE0/EOP detection. All outputs are one-cycle pulses.
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic pkt_active,
  output logic bit_valid,
  output logic bit_val,
  output logic se0,
  output logic eop,
  output logic stuff_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] CNT_MAX   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SAMPLE_AT = TW'(CLKS_PER_BIT / 2);

  logic          r_dp_meta, r_dp_sync, r_dp_last;
  logic          r_dm_meta, r_dm_sync;
  logic [TW-1:0] r_timer;
  bus_state_e    r_prev;
  logic [2:0]    r_ones;
  logic [1:0]    r_se0_cnt;
  bus_state_e    w_bus;
  logic          w_edge;
  logic          w_bit;

  always_comb begin
    unique case ({r_dp_sync, r_dm_sync})
      2'b10:   w_bus = BUS_J;
      2'b01:   w_bus = BUS_K;
      default: w_bus = BUS_SE0;
    endcase
  end

  assign w_edge = r_dp_sync ^ r_dp_last;
  assign w_bit  = (w_bus == r_prev);

  // NOTE: every register here uses <= so all flops see pre-edge values,
  // which is what makes the two-flop synchronizer chain actually two stages.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dp_meta <= 1'b0;
      r_dp_sync <= 1'b0;
      r_dp_last <= 1'b0;
      r_dm_meta <= 1'b0;
      r_dm_sync <= 1'b0;
      r_timer   <= '0;
      r_prev    <= BUS_J;
      r_ones    <= '0;
      r_se0_cnt <= '0;
      bit_valid <= 1'b0;
      bit_val   <= 1'b0;
      se0       <= 1'b0;
      eop       <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      r_dp_meta <= d_plus;
      r_dp_sync <= r_dp_meta;
      r_dp_last <= r_dp_sync;
      r_dm_meta <= d_minus;
      r_dm_sync <= r_dm_meta;
      bit_valid <= 1'b0;
      se0       <= 1'b0;
      eop       <= 1'b0;
      stuff_err <= 1'b0;

      if (w_edge || r_timer == CNT_MAX) r_timer <= '0;
      else                              r_timer <= r_timer + 1'b1;

      if (r_timer == SAMPLE_AT) begin
        if (w_bus == BUS_SE0) begin
          se0    <= 1'b1;
          r_prev <= BUS_J;
          r_ones <= '0;
          if (r_se0_cnt != 2'd3) r_se0_cnt <= r_se0_cnt + 2'd1;
        end else if (r_se0_cnt != 2'd0) begin
          // First non-SE0 sample after SE0 never carries data.
          eop       <= (r_se0_cnt >= 2'd2) && (w_bus == BUS_J);
          r_se0_cnt <= '0;
          r_prev    <= w_bus;
        end else begin
          r_prev <= w_bus;
          if (!pkt_active) begin
            bit_valid <= 1'b1;
            bit_val   <= w_bit;
            r_ones    <= '0;
          end else if (r_ones == 3'd6) begin
            stuff_err <= w_bit;
            r_ones    <= '0;
          end else begin
            bit_valid <= 1'b1;
            bit_val   <= w_bit;
            r_ones    <= w_bit ? r_ones + 3'd1 : 3'd0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/usb_rx_core.sv
// Packet layer of the USB receiver: SYNC/PID checking, packet FSM, CRC16,
// and a 2-byte delay so trailing CRC bytes never reach the endpoint FIFO.
module usb_rx_core
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [2:0] rx_packet,
  output logic [7:0] rx_packet_data,
  output logic       store_rx_packet_data
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_BODY, ST_EOP_WAIT, ST_DONE, ST_ERR
  } state_e;

  state_e      r_state;
  rx_code_e    r_rx_packet;
  pkt_kind_e   r_kind;
  logic [7:0]  r_shift, r_buf0, r_buf1, r_data;
  logic [2:0]  r_bit_cnt, r_idle_cnt;
  logic [1:0]  r_buf_cnt;
  logic [15:0] r_crc;
  logic        r_store;
  logic        w_bit_valid, w_bit_val, w_se0, w_eop, w_stuff_err, w_pkt_active;
  logic [7:0]  w_byte;
  logic        w_byte_done;

  assign w_pkt_active = (r_state == ST_SYNC) || (r_state == ST_PID) ||
                        (r_state == ST_BODY) || (r_state == ST_EOP_WAIT);
  assign w_byte       = {w_bit_val, r_shift[7:1]};
  assign w_byte_done  = w_bit_valid && (r_bit_cnt == 3'd7);

  usb_rx_bit_decoder #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_decoder (
    .clk        (clk),
    .n_rst      (n_rst),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .pkt_active (w_pkt_active),
    .bit_valid  (w_bit_valid),
    .bit_val    (w_bit_val),
    .se0        (w_se0),
    .eop        (w_eop),
    .stuff_err  (w_stuff_err)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_rx_packet <= RX_IDLE;
      r_kind      <= PK_TOKEN;
      r_shift     <= '0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_data      <= '0;
      r_bit_cnt   <= '0;
      r_idle_cnt  <= '0;
      r_buf_cnt   <= '0;
      r_crc       <= '0;
      r_store     <= 1'b0;
    end else begin
      r_store <= 1'b0;
      if (r_state != ST_ERR) r_idle_cnt <= '0;

      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_bit_valid && !w_bit_val) begin
            r_state     <= ST_SYNC;
            r_rx_packet <= RX_IDLE;
            r_shift     <= w_byte;
            r_bit_cnt   <= 3'd1;
            r_crc       <= CRC16_INIT;
            r_buf_cnt   <= '0;
          end
        end

        ST_SYNC, ST_PID: begin
          if (w_se0 || w_stuff_err) begin
            r_state     <= ST_ERR;
            r_rx_packet <= RX_ERROR;
          end else if (w_bit_valid) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done && r_state == ST_SYNC) begin
              r_state <= (w_byte == SYNC_BYTE) ? ST_PID : ST_ERR;
              if (w_byte != SYNC_BYTE) r_rx_packet <= RX_ERROR;
            end else if (w_byte_done) begin
              r_state <= ST_BODY;
              if (w_byte[7:4] != ~w_byte[3:0]) begin
                r_state     <= ST_ERR;
                r_rx_packet <= RX_ERROR;
              end else begin
                unique case (w_byte)
                  PID_OUT: begin r_rx_packet <= RX_OUT;  r_kind <= PK_TOKEN;     end
                  PID_IN:  begin r_rx_packet <= RX_IN;   r_kind <= PK_TOKEN;     end
                  PID_ACK: begin r_rx_packet <= RX_ACK;  r_kind <= PK_HANDSHAKE; end
                  PID_NAK: begin r_rx_packet <= RX_NAK;  r_kind <= PK_HANDSHAKE; end
                  PID_DATA0, PID_DATA1: begin
                    r_rx_packet <= RX_DATA;
                    r_kind      <= PK_DATA;
                  end
                  default: begin
                    r_state     <= ST_ERR;
                    r_rx_packet <= RX_ERROR;
                  end
                endcase
              end
            end
          end
        end

        ST_BODY: begin
          if (w_stuff_err || (w_se0 && r_bit_cnt != 3'd0)) begin
            r_state     <= ST_ERR;
            r_rx_packet <= RX_ERROR;
          end else if (w_se0) begin
            r_state <= ST_EOP_WAIT;
          end else if (w_bit_valid) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_kind == PK_DATA) r_crc <= crc16_next(r_crc, w_bit_val);
            if (w_byte_done && r_kind == PK_HANDSHAKE) begin
              r_state     <= ST_ERR;
              r_rx_packet <= RX_ERROR;
            end else if (w_byte_done && r_kind == PK_DATA) begin
              // The newest two bytes may be CRC16, so only the third-last leaves.
              if (r_buf_cnt == 2'd2) begin
                r_data  <= r_buf1;
                r_store <= 1'b1;
              end else begin
                r_buf_cnt <= r_buf_cnt + 2'd1;
              end
              r_buf1 <= r_buf0;
              r_buf0 <= w_byte;
            end
          end
        end

        ST_EOP_WAIT: begin
          if (w_eop) begin
            if (r_kind == PK_DATA && (r_crc != CRC16_RESIDUAL || r_buf_cnt != 2'd2)) begin
              r_state     <= ST_IDLE;
              r_rx_packet <= RX_ERROR;
            end else begin
              r_state     <= ST_DONE;
              r_rx_packet <= RX_DONE;
            end
          end else if (w_bit_valid || w_stuff_err) begin
            r_state     <= ST_ERR;
            r_rx_packet <= RX_ERROR;
          end
        end

        ST_ERR: begin
          if (w_eop) begin
            r_state <= ST_IDLE;
          end else if (w_se0) begin
            r_idle_cnt <= '0;
          end else if (w_bit_valid) begin
            r_idle_cnt <= w_bit_val ? r_idle_cnt + 3'd1 : 3'd0;
            if (w_bit_val && r_idle_cnt == 3'd7) r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_packet            = r_rx_packet;
  assign rx_packet_data       = r_data;
  assign store_rx_packet_data = r_store;

endmodule

// File: tb/tb_usb_rx_core.sv
// Directed bench for usb_rx_core: NRZI/bit-stuffing line driver plus
// per-scenario tasks with hand-computed expected status codes and bytes.
module tb_usb_rx_core;

  localparam int CLKS_PER_BIT = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_plus;
  logic       d_minus;
  logic [2:0] rx_packet;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data;

  int checks = 0;
  int errors = 0;

  logic       tx_k;
  int         tx_ones;
  logic [7:0] strobe_q[$];
  logic       store_prev = 1'b0;
  int         wide_cnt = 0;

  always #5 clk = ~clk;

  usb_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .d_plus               (d_plus),
    .d_minus              (d_minus),
    .rx_packet            (rx_packet),
    .rx_packet_data       (rx_packet_data),
    .store_rx_packet_data (store_rx_packet_data)
  );

  always @(negedge clk) begin
    if (store_rx_packet_data) strobe_q.push_back(rx_packet_data);
    if (store_rx_packet_data && store_prev) wide_cnt++;
    store_prev = store_rx_packet_data;
  end

  // ---------------- line driver ----------------
  task automatic drive(input logic dp, input logic dm);
    d_plus  = dp;
    d_minus = dm;
    repeat (CLKS_PER_BIT) @(negedge clk);
  endtask

  task automatic send_raw(input logic b);
    if (!b) tx_k = ~tx_k;
    drive(~tx_k, tx_k);
  endtask

  task automatic send_bit(input logic b);
    send_raw(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 6) begin
        send_raw(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic start_packet();
    tx_k    = 1'b0;
    tx_ones = 0;
  endtask

  task automatic send_eop();
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    tx_k = 1'b0;
  endtask

  task automatic idle_bits(input int n);
    repeat (n) drive(1'b1, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_rst   = 1'b0;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rx_packet !== 3'b000) begin
      errors++;
      $display("FAIL reset_rx_packet: got=%b want=%b", rx_packet, 3'b000);
    end
    n_rst = 1'b1;
    idle_bits(10);
    checks++;
    if (rx_packet !== 3'b000) begin
      errors++;
      $display("FAIL idle_rx_packet: got=%b want=%b", rx_packet, 3'b000);
    end
    checks++;
    if (rx_packet_data !== 8'h00) begin
      errors++;
      $display("FAIL idle_rx_packet_data: got=%h want=%h", rx_packet_data, 8'h00);
    end
    checks++;
    if (store_rx_packet_data !== 1'b0 || strobe_q.size() != 0) begin
      errors++;
      $display("FAIL idle_strobe: got=%b/%0d want=0/0", store_rx_packet_data, strobe_q.size());
    end
  endtask

  task automatic test_token_out();
    int base;
    base = strobe_q.size();
    start_packet();
    send_byte(8'h80);
    send_byte(8'hE1);
    send_byte(8'h00);
    checks++;
    if (rx_packet !== 3'b010) begin
      errors++;
      $display("FAIL token_pid: got=%b want=%b", rx_packet, 3'b010);
    end
    send_byte(8'h29);
    send_eop();
    idle_bits(2);
    checks++;
    if (rx_packet !== 3'b101) begin
      errors++;
      $display("FAIL token_done: got=%b want=%b", rx_packet, 3'b101);
    end
    checks++;
    if (strobe_q.size() != base) begin
      errors++;
      $display("FAIL token_no_strobe: got=%0d want=%0d", strobe_q.size() - base, 0);
    end
  endtask

  // Payload AA AF; correct CRC16 bytes are C0 93.
  task automatic data_packet(input string name, input logic [7:0] crc_hi, input logic [2:0] want_end);
    int base;
    base = strobe_q.size();
    start_packet();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'hAA);
    checks++;
    if (rx_packet !== 3'b110) begin
      errors++;
      $display("FAIL %s_pid: got=%b want=%b", name, rx_packet, 3'b110);
    end
    send_byte(8'hAF);
    send_byte(8'hC0);
    send_byte(crc_hi);
    send_eop();
    idle_bits(2);
    checks++;
    if (strobe_q.size() - base != 2) begin
      errors++;
      $display("FAIL %s_strobe_count: got=%0d want=%0d", name, strobe_q.size() - base, 2);
    end
    checks++;
    if (strobe_q.size() < base + 1 || strobe_q[base] !== 8'hAA) begin
      errors++;
      $display("FAIL %s_byte0: got=%h want=%h", name,
               (strobe_q.size() > base) ? strobe_q[base] : 8'hxx, 8'hAA);
    end
    checks++;
    if (strobe_q.size() < base + 2 || strobe_q[base+1] !== 8'hAF) begin
      errors++;
      $display("FAIL %s_byte1: got=%h want=%h", name,
               (strobe_q.size() > base + 1) ? strobe_q[base+1] : 8'hxx, 8'hAF);
    end
    checks++;
    if (rx_packet !== want_end) begin
      errors++;
      $display("FAIL %s_end: got=%b want=%b", name, rx_packet, want_end);
    end
    checks++;
    if (rx_packet_data !== 8'hAF) begin
      errors++;
      $display("FAIL %s_last_data: got=%h want=%h", name, rx_packet_data, 8'hAF);
    end
  endtask

  task automatic test_data_crc_ok();
    data_packet("data_ok", 8'h93, 3'b101);
  endtask

  task automatic test_data_crc_bad();
    data_packet("data_bad", 8'h92, 3'b111);
  endtask

  task automatic test_bad_sync_then_ack();
    logic [7:0] sync_b;
    sync_b = 8'h80;
    start_packet();
    send_byte(8'h88);
    send_eop();
    idle_bits(2);
    checks++;
    if (rx_packet !== 3'b111) begin
      errors++;
      $display("FAIL bad_sync: got=%b want=%b", rx_packet, 3'b111);
    end
    start_packet();
    send_bit(sync_b[0]);
    send_bit(sync_b[1]);
    checks++;
    if (rx_packet !== 3'b000) begin
      errors++;
      $display("FAIL first_k_clears: got=%b want=%b", rx_packet, 3'b000);
    end
    for (int i = 2; i < 8; i++) send_bit(sync_b[i]);
    send_byte(8'hD2);
    drive(1'b0, 1'b0);
    checks++;
    if (rx_packet !== 3'b011) begin
      errors++;
      $display("FAIL ack_pid: got=%b want=%b", rx_packet, 3'b011);
    end
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    idle_bits(2);
    checks++;
    if (rx_packet !== 3'b101) begin
      errors++;
      $display("FAIL ack_done: got=%b want=%b", rx_packet, 3'b101);
    end
  endtask

  task automatic test_se0_mid_byte();
    start_packet();
    send_byte(8'h80);
    send_byte(8'h69);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (rx_packet !== 3'b001) begin
      errors++;
      $display("FAIL in_pid: got=%b want=%b", rx_packet, 3'b001);
    end
    send_eop();
    idle_bits(2);
    checks++;
    if (rx_packet !== 3'b111) begin
      errors++;
      $display("FAIL se0_mid_byte: got=%b want=%b", rx_packet, 3'b111);
    end
  endtask

  task automatic test_reset_mid_packet();
    start_packet();
    send_byte(8'h80);
    send_byte(8'h69);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (rx_packet !== 3'b001 || rx_packet_data !== 8'hAF) begin
      errors++;
      $display("FAIL pre_reset: got=%b/%h want=%b/%h", rx_packet, rx_packet_data, 3'b001, 8'hAF);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (rx_packet !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_rx_packet: got=%b want=%b", rx_packet, 3'b000);
    end
    checks++;
    if (rx_packet_data !== 8'h00 || store_rx_packet_data !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_data: got=%h/%b want=%h/%b", rx_packet_data, store_rx_packet_data, 8'h00, 1'b0);
    end
    d_plus  = 1'b1;
    d_minus = 1'b0;
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    idle_bits(10);
    checks++;
    if (rx_packet !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: got=%b want=%b", rx_packet, 3'b000);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_token_out();
    test_data_crc_ok();
    test_data_crc_bad();
    test_bad_sync_then_ack();
    test_se0_mid_byte();
    test_reset_mid_packet();
    checks++;
    if (wide_cnt != 0) begin
      errors++;
      $display("FAIL strobe_width: got=%0d wide pulses want=%0d", wide_cnt, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
